// File: rtl/dt_pkg.sv
// Shared decision-tree definitions: node word layout, frame marker,
// loader error codes and loader FSM encoding.
package dt_pkg;

   localparam logic [7:0]  SOF_BYTE       = 8'hA5;
   localparam logic [15:0] LEAF_THRESHOLD = 16'hFFFF;

   localparam int SEL_MSB  = 31;
   localparam int SEL_LSB  = 28;
   localparam int THR_MSB  = 27;
   localparam int THR_LSB  = 12;
   localparam int TPTR_MSB = 11;
   localparam int TPTR_LSB = 8;
   localparam int FPTR_MSB = 7;
   localparam int FPTR_LSB = 0;

   typedef enum logic [1:0] {
      ERR_ABORT   = 2'd0,
      ERR_CSUM    = 2'd1,
      ERR_TIMEOUT = 2'd2,
      ERR_PTR     = 2'd3
   } err_code_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COUNT   = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CSUM    = 3'd3,
      ST_DONE    = 3'd4,
      ST_ERR     = 3'd5
   } ld_state_e;

   function automatic logic is_leaf(input logic [31:0] w);
      return w[THR_MSB:THR_LSB] == LEAF_THRESHOLD;
   endfunction

endpackage

// File: rtl/dt_word_assembler.sv
// Packs payload bytes MSB-first into 32-bit node words and keeps the frame XOR.
// Ports: clr (SOF), cnt_en/byte_en (accepted CNT/payload byte), data, word_done, word_valid, word, csum.
module dt_word_assembler (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        cnt_en,
   input  logic        byte_en,
   input  logic [7:0]  data,
   output logic        word_done,
   output logic        word_valid,
   output logic [31:0] word,
   output logic [7:0]  csum
);

   logic [1:0] byte_cnt;

   // High on the handshake of the 4th byte of a word
   assign word_done = byte_en & (byte_cnt == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt   <= 2'd0;
         word_valid <= 1'b0;
         word       <= 32'd0;
         csum       <= 8'd0;
      end else begin
         word_valid <= word_done;
         if (clr) begin
            byte_cnt <= 2'd0;
            csum     <= 8'd0;
         end else begin
            if (cnt_en | byte_en)
               csum <= csum ^ data;
            if (byte_en) begin
               byte_cnt <= byte_cnt + 2'd1;
               word     <= {word[23:0], data};
            end
         end
      end
   end

endmodule

// File: rtl/dt_node_loader.sv
// Framed byte stream to node RAM writer; frame = SOF, CNT, CNT*4 bytes, CSUM.
// Ports: in_data/in_valid/in_ready stream, abort, wr_en/wr_addr/wr_data RAM port,
// load_busy/load_done/load_err/err_code status, tree_valid, nodes_loaded.
// Optional macro DT_NODE_CHECK_EN enables node pointer range checks.
module dt_node_loader #(
   parameter int          ADDR_W   = 8,
   parameter logic [7:0]  SOF_BYTE = 8'hA5,
   parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              abort,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              load_busy,
   output logic              load_done,
   output logic              load_err,
   output logic [1:0]        err_code,
   output logic              tree_valid,
   output logic [ADDR_W:0]   nodes_loaded
);

   import dt_pkg::*;

   localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

   ld_state_e       state, state_nxt;
   err_code_e       err_nxt;
   logic            go_done, go_err;
   logic            hs, sof_hs, in_frame;
   logic            tmo_hit, ptr_ok, ptr_fail, last_word;
   logic [15:0]     tmo_cnt;
   logic [ADDR_W:0] n_reg, words_rx, n_calc;
   logic            word_done, word_valid;
   logic [31:0]     word;
   logic [7:0]      csum;

   assign in_frame = (state == ST_COUNT) | (state == ST_PAYLOAD) |
                     (state == ST_CSUM);
   assign in_ready = ~abort & (in_frame | (state == ST_IDLE));
   assign hs       = in_valid & in_ready;
   assign sof_hs   = hs & (state == ST_IDLE) & (in_data == SOF_BYTE);
   assign tmo_hit  = ~hs & (tmo_cnt == TIMEOUT - 16'd1);

   // CNT of zero encodes a full RAM
   assign n_calc = (in_data == 8'h00) ? {1'b1, {ADDR_W{1'b0}}}
                                      : (ADDR_W+1)'(in_data);
   assign last_word = word_done & (words_rx + ONE == n_reg);

   dt_word_assembler u_asm (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (sof_hs),
      .cnt_en     (hs & (state == ST_COUNT)),
      .byte_en    (hs & (state == ST_PAYLOAD)),
      .data       (in_data),
      .word_done  (word_done),
      .word_valid (word_valid),
      .word       (word),
      .csum       (csum)
   );

`ifdef DT_NODE_CHECK_EN
   logic [ADDR_W:0] fptr, tptr;
   assign fptr = (ADDR_W+1)'(word[FPTR_MSB:FPTR_LSB]);
   // True pointer 0 means the next sequential node
   assign tptr = (word[TPTR_MSB:TPTR_LSB] == 4'd0)
               ? ({1'b0, wr_addr} + ONE)
               : (ADDR_W+1)'(word[TPTR_MSB:TPTR_LSB]);
   assign ptr_ok = is_leaf(word) | ((fptr < n_reg) & (tptr < n_reg));
`else
   assign ptr_ok = 1'b1;
`endif

   assign ptr_fail = word_valid & ~ptr_ok;
   assign wr_en    = word_valid & ptr_ok;
   assign wr_data  = word;

   assign load_done = (state == ST_DONE);
   assign load_err  = (state == ST_ERR);

   always_comb begin
      state_nxt = state;
      go_done   = 1'b0;
      go_err    = 1'b0;
      err_nxt   = ERR_ABORT;
      unique case (state)
         ST_IDLE: begin
            if (sof_hs)
               state_nxt = ST_COUNT;
         end
         ST_COUNT, ST_PAYLOAD, ST_CSUM: begin
            if (abort) begin
               go_err  = 1'b1;
               err_nxt = ERR_ABORT;
            end else if (ptr_fail) begin
               go_err  = 1'b1;
               err_nxt = ERR_PTR;
            end else if (tmo_hit) begin
               go_err  = 1'b1;
               err_nxt = ERR_TIMEOUT;
            end else if (hs) begin
               if (state == ST_COUNT) begin
                  state_nxt = ST_PAYLOAD;
               end else if (state == ST_PAYLOAD) begin
                  if (last_word)
                     state_nxt = ST_CSUM;
               end else if (in_data == csum) begin
                  go_done = 1'b1;
               end else begin
                  go_err  = 1'b1;
                  err_nxt = ERR_CSUM;
               end
            end
            if (go_err)
               state_nxt = ST_ERR;
            else if (go_done)
               state_nxt = ST_DONE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         tmo_cnt      <= 16'd0;
         n_reg        <= '0;
         words_rx     <= '0;
         wr_addr      <= '0;
         load_busy    <= 1'b0;
         err_code     <= 2'd0;
         tree_valid   <= 1'b0;
         nodes_loaded <= '0;
      end else begin
         state <= state_nxt;

         if (in_frame & ~hs)
            tmo_cnt <= tmo_cnt + 16'd1;
         else
            tmo_cnt <= 16'd0;

         if (hs & (state == ST_COUNT))
            n_reg <= n_calc;

         if (sof_hs)
            words_rx <= '0;
         else if (word_done)
            words_rx <= words_rx + ONE;

         if (sof_hs)
            wr_addr <= '0;
         else if (wr_en)
            wr_addr <= wr_addr + 1'b1;

         if (sof_hs) begin
            tree_valid <= 1'b0;
            err_code   <= 2'd0;
            load_busy  <= 1'b1;
         end else if (go_done) begin
            tree_valid   <= 1'b1;
            nodes_loaded <= n_reg;
            load_busy    <= 1'b0;
         end else if (go_err) begin
            err_code  <= err_nxt;
            load_busy <= 1'b0;
         end
      end
   end

endmodule
